// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Optional grant statistics are enabled with SDRAM_ARB_STATS_EN.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // Bit 1 set means a read port; bit 0 selects buffer 0 or buffer 1.
    localparam logic [1:0] PORT_WR0 = 2'd0;
    localparam logic [1:0] PORT_WR1 = 2'd1;
    localparam logic [1:0] PORT_RD0 = 2'd2;
    localparam logic [1:0] PORT_RD1 = 2'd3;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/sdram_arb_addr_gen.sv
// One burst address pointer: starts at BASE, steps by BURST_LEN and wraps
// back to BASE at the end of the frame buffer.
module sdram_arb_addr_gen #(
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] BASE        = '0,
    parameter int                FRAME_WORDS = 307200,
    parameter int                BURST_LEN   = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr
);

    // One extra bit so base + frame size cannot overflow the compare.
    localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(FRAME_WORDS);

    logic [ADDR_W:0] stepped;

    assign stepped = {1'b0, ptr} + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= BASE;
        end else if (load) begin
            ptr <= BASE;
        end else if (advance) begin
            ptr <= (stepped >= LIMIT) ? BASE : stepped[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Burst scheduler sharing the SDRAM command engine between two write and two
// read frame-buffer ports, with refresh first. Macro SDRAM_ARB_STATS_EN adds oSTAT.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int                BURST_LEN   = 80,
    parameter int                FIFO_DEPTH  = 512,
    parameter int                USEDW_W     = 9,
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] BUF0_BASE   = '0,
    parameter logic [ADDR_W-1:0] BUF1_BASE   = 23'h100000,
    parameter int                FRAME_WORDS = 307200
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [USEDW_W-1:0] iWR0_USEDW,
    input  logic [USEDW_W-1:0] iWR1_USEDW,
    input  logic [USEDW_W-1:0] iRD0_USEDW,
    input  logic [USEDW_W-1:0] iRD1_USEDW,
    input  logic               iLOAD,
    input  logic               iREF_REQ,
    output logic               oCMD_VALID,
    input  logic               iCMD_READY,
    input  logic               iCMD_DONE,
    output logic               oCMD_REFRESH,
    output logic               oCMD_WRITE,
    output logic [1:0]         oCMD_PORT,
    output logic [ADDR_W-1:0]  oCMD_ADDR,
    output logic [8:0]         oCMD_LEN,
    output logic               oBUSY
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [4*STAT_W-1:0] oSTAT
`endif
);

    localparam logic [USEDW_W-1:0] WR_THRESH = USEDW_W'(BURST_LEN);
    localparam logic [USEDW_W-1:0] RD_THRESH = USEDW_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [8:0]         LEN_BURST = 9'(BURST_LEN);

    arb_state_e state;
    arb_state_e state_next;

    logic              sampled;
    logic              ref_q;
    logic [1:0]        wr_elig_q;
    logic [1:0]        rd_elig_q;
    logic              rr_wr;
    logic              rr_rd;

    logic              win_ref;
    logic [1:0]        win_port;
    logic              win_any;
    logic              rd_toggle;
    logic              wr_toggle;
    logic              load_cmd;
    logic              accept;
    logic [3:0]        advance;
    logic [ADDR_W-1:0] ptr [4];

    assign oCMD_VALID = (state == ST_OFFER);
    assign oBUSY      = (state == ST_BUSY);
    assign accept     = (state == ST_OFFER) && iCMD_READY;

    // Index bit 0 picks the buffer, so WR0/RD0 share BUF0 and WR1/RD1 share BUF1.
    for (genvar g = 0; g < 4; g++) begin : g_ptr
        assign advance[g] = accept && !oCMD_REFRESH && (oCMD_PORT == 2'(g));

        sdram_arb_addr_gen #(
            .ADDR_W     (ADDR_W),
            .BASE       ((g % 2 == 1) ? BUF1_BASE : BUF0_BASE),
            .FRAME_WORDS(FRAME_WORDS),
            .BURST_LEN  (BURST_LEN)
        ) u_addr_gen (
            .clk    (iCLK),
            .rst_n  (iRST_N),
            .load   (iLOAD),
            .advance(advance[g]),
            .ptr    (ptr[g])
        );
    end

    // Winner selection works on the snapshot taken in IDLE, never on live levels.
    always_comb begin
        win_ref   = 1'b0;
        win_port  = PORT_WR0;
        win_any   = 1'b0;
        rd_toggle = 1'b0;
        wr_toggle = 1'b0;
        if (ref_q) begin
            win_ref = 1'b1;
            win_any = 1'b1;
        end else if (|rd_elig_q) begin
            win_any   = 1'b1;
            rd_toggle = &rd_elig_q;
            if (&rd_elig_q) begin
                win_port = rr_rd ? PORT_RD1 : PORT_RD0;
            end else begin
                win_port = rd_elig_q[1] ? PORT_RD1 : PORT_RD0;
            end
        end else if (|wr_elig_q) begin
            win_any   = 1'b1;
            wr_toggle = &wr_elig_q;
            if (&wr_elig_q) begin
                win_port = rr_wr ? PORT_WR1 : PORT_WR0;
            end else begin
                win_port = wr_elig_q[1] ? PORT_WR1 : PORT_WR0;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sampled && win_any) begin
                    state_next = ST_OFFER;
                    load_cmd   = 1'b1;
                end
            end
            ST_OFFER: begin
                if (iCMD_READY) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (iCMD_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The snapshot is only trusted after a full edge spent in IDLE, which
    // gives the one-cycle decision latency after reset and after each done.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sampled   <= 1'b0;
            ref_q     <= 1'b0;
            wr_elig_q <= 2'b00;
            rd_elig_q <= 2'b00;
        end else begin
            sampled   <= (state == ST_IDLE) && (state_next == ST_IDLE);
            ref_q     <= iREF_REQ;
            wr_elig_q <= {iWR1_USEDW >= WR_THRESH, iWR0_USEDW >= WR_THRESH};
            rd_elig_q <= {iRD1_USEDW <= RD_THRESH, iRD0_USEDW <= RD_THRESH};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rr_wr        <= 1'b0;
            rr_rd        <= 1'b0;
            oCMD_REFRESH <= 1'b0;
            oCMD_WRITE   <= 1'b0;
            oCMD_PORT    <= PORT_WR0;
            oCMD_ADDR    <= '0;
            oCMD_LEN     <= '0;
        end else if (load_cmd) begin
            if (rd_toggle) begin
                rr_rd <= ~rr_rd;
            end
            if (wr_toggle) begin
                rr_wr <= ~rr_wr;
            end
            oCMD_REFRESH <= win_ref;
            oCMD_WRITE   <= !win_ref && !win_port[1];
            oCMD_PORT    <= win_ref ? PORT_WR0 : win_port;
            oCMD_ADDR    <= win_ref ? '0 : ptr[win_port];
            oCMD_LEN     <= win_ref ? 9'd0 : LEN_BURST;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [4];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 4; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (iLOAD) begin
                    stat_cnt[i] <= '0;
                end else if (advance[i]) begin
                    stat_cnt[i] <= sat_inc(stat_cnt[i]);
                end
            end
        end
    end

    assign oSTAT = {stat_cnt[3], stat_cnt[2], stat_cnt[1], stat_cnt[0]};
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter; oSTAT checks are
// compiled in when SDRAM_ARB_STATS_EN is defined.
module tb_sdram_port_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [8:0]  iWR0_USEDW, iWR1_USEDW, iRD0_USEDW, iRD1_USEDW;
    logic        iLOAD, iREF_REQ, iCMD_READY, iCMD_DONE;
    logic        oCMD_VALID, oCMD_REFRESH, oCMD_WRITE, oBUSY;
    logic [1:0]  oCMD_PORT;
    logic [22:0] oCMD_ADDR;
    logic [8:0]  oCMD_LEN;
`ifdef SDRAM_ARB_STATS_EN
    logic [63:0] oSTAT;
`endif

    int total = 0;
    int bad   = 0;

    always #5 iCLK = ~iCLK;

    sdram_port_arbiter dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iWR0_USEDW  (iWR0_USEDW),
        .iWR1_USEDW  (iWR1_USEDW),
        .iRD0_USEDW  (iRD0_USEDW),
        .iRD1_USEDW  (iRD1_USEDW),
        .iLOAD       (iLOAD),
        .iREF_REQ    (iREF_REQ),
        .oCMD_VALID  (oCMD_VALID),
        .iCMD_READY  (iCMD_READY),
        .iCMD_DONE   (iCMD_DONE),
        .oCMD_REFRESH(oCMD_REFRESH),
        .oCMD_WRITE  (oCMD_WRITE),
        .oCMD_PORT   (oCMD_PORT),
        .oCMD_ADDR   (oCMD_ADDR),
        .oCMD_LEN    (oCMD_LEN),
        .oBUSY       (oBUSY)
`ifdef SDRAM_ARB_STATS_EN
        ,
        .oSTAT       (oSTAT)
`endif
    );

    // {refresh, write, port, addr, len}
    function automatic logic [35:0] cmd_fields();
        return {oCMD_REFRESH, oCMD_WRITE, oCMD_PORT, oCMD_ADDR, oCMD_LEN};
    endfunction

    // Reads idle at 511 (full, not eligible); writes idle at 0.
    task automatic reset_dut();
        iRST_N = 1'b0;
        iWR0_USEDW = 9'd0;   iWR1_USEDW = 9'd0;
        iRD0_USEDW = 9'd511; iRD1_USEDW = 9'd511;
        iLOAD = 1'b0; iREF_REQ = 1'b0; iCMD_READY = 1'b0; iCMD_DONE = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (oCMD_VALID) begin
                ok = 1'b1;
                break;
            end
            @(negedge iCLK);
        end
    endtask

    task automatic accept_and_done();
        iCMD_READY = 1'b1;
        @(negedge iCLK);
        iCMD_READY = 1'b0;
        iCMD_DONE  = 1'b1;
        @(negedge iCLK);
        iCMD_DONE  = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        iRST_N = 1'b0;
        iWR0_USEDW = 9'd80;
        @(negedge iCLK);
        total++;
        if ({oCMD_VALID, oBUSY, cmd_fields()} !== 38'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {oCMD_VALID, oBUSY, cmd_fields()});
        end
    endtask

    task automatic test_first_write();
        reset_dut();
        iWR0_USEDW = 9'd80;
        @(negedge iCLK);
        total++;
        if (oCMD_VALID !== 1'b0) begin
            bad++; $display("FAIL latency_edge1 valid got=%b want=0", oCMD_VALID);
        end
        @(negedge iCLK);
        total++;
        if ({oCMD_VALID, cmd_fields()} !== {1'b1, 1'b0, 1'b1, 2'd0, 23'd0, 9'd80}) begin
            bad++; $display("FAIL first_wr0_cmd got=%h want=%h", {oCMD_VALID, cmd_fields()},
                            {1'b1, 1'b0, 1'b1, 2'd0, 23'd0, 9'd80});
        end
        iCMD_READY = 1'b1;
        @(negedge iCLK);
        iCMD_READY = 1'b0;
        total++;
        if ({oBUSY, oCMD_VALID} !== 2'b10) begin
            bad++; $display("FAIL busy_after_accept busy,valid got=%b want=10", {oBUSY, oCMD_VALID});
        end
        iCMD_DONE = 1'b1;
        @(negedge iCLK);
        iCMD_DONE = 1'b0;
        total++;
        if ({oBUSY, oCMD_VALID} !== 2'b00) begin
            bad++; $display("FAIL idle_after_done busy,valid got=%b want=00", {oBUSY, oCMD_VALID});
        end
        @(negedge iCLK);
        total++;
        if (oCMD_VALID !== 1'b0) begin
            bad++; $display("FAIL gap_after_done valid got=%b want=0", oCMD_VALID);
        end
        @(negedge iCLK);
        total++;
        if ({oCMD_VALID, oCMD_PORT, oCMD_ADDR} !== {1'b1, 2'd0, 23'd80}) begin
            bad++; $display("FAIL second_wr0 valid,port,addr got=%h want=%h",
                            {oCMD_VALID, oCMD_PORT, oCMD_ADDR}, {1'b1, 2'd0, 23'd80});
        end
        iWR0_USEDW = 9'd0;
        accept_and_done();
    endtask

    task automatic test_priority();
        bit ok;
        reset_dut();
        iREF_REQ = 1'b1; iRD0_USEDW = 9'd0; iWR1_USEDW = 9'd200;
        wait_valid(ok);
        total++;
        if (!ok || cmd_fields() !== {1'b1, 1'b0, 2'd0, 23'd0, 9'd0}) begin
            bad++; $display("FAIL prio_refresh ok=%b got=%h want=%h", ok, cmd_fields(),
                            {1'b1, 1'b0, 2'd0, 23'd0, 9'd0});
        end
        iREF_REQ = 1'b0;
        accept_and_done();
        wait_valid(ok);
        total++;
        if (!ok || cmd_fields() !== {1'b0, 1'b0, 2'd2, 23'd0, 9'd80}) begin
            bad++; $display("FAIL prio_rd0 ok=%b got=%h want=%h", ok, cmd_fields(),
                            {1'b0, 1'b0, 2'd2, 23'd0, 9'd80});
        end
        iRD0_USEDW = 9'd511;
        accept_and_done();
        wait_valid(ok);
        total++;
        if (!ok || cmd_fields() !== {1'b0, 1'b1, 2'd1, 23'h100000, 9'd80}) begin
            bad++; $display("FAIL prio_wr1 ok=%b got=%h want=%h", ok, cmd_fields(),
                            {1'b0, 1'b1, 2'd1, 23'h100000, 9'd80});
        end
        iWR1_USEDW = 9'd0;
        accept_and_done();
    endtask

    task automatic test_read_rr();
        bit ok;
        logic [1:0]  exp_port [4];
        logic [22:0] exp_addr [4];
        exp_port = '{2'd2, 2'd3, 2'd2, 2'd3};
        exp_addr = '{23'd0, 23'h100000, 23'd80, 23'h100050};
        reset_dut();
        iRD0_USEDW = 9'd0; iRD1_USEDW = 9'd0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            total++;
            if (!ok || {oCMD_WRITE, oCMD_PORT, oCMD_ADDR} !== {1'b0, exp_port[i], exp_addr[i]}) begin
                bad++; $display("FAIL read_rr[%0d] ok=%b port=%0d addr=%h want port=%0d addr=%h",
                                i, ok, oCMD_PORT, oCMD_ADDR, exp_port[i], exp_addr[i]);
            end
            if (i == 3) begin
                iRD0_USEDW = 9'd511; iRD1_USEDW = 9'd511;
            end
            accept_and_done();
        end
    endtask

    task automatic test_wrap();
        bit ok;
        reset_dut();
        iWR1_USEDW = 9'd200;
        for (int i = 0; i < 3840; i++) begin
            wait_valid(ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL wrap_timeout burst=%0d valid got=0 want=1", i);
                break;
            end
            if (i == 0) begin
                total++;
                if (oCMD_ADDR !== 23'h100000) begin
                    bad++; $display("FAIL wrap_first addr got=%h want=100000", oCMD_ADDR);
                end
            end
            if (i == 3839) begin
                total++;
                if ({oCMD_PORT, oCMD_ADDR} !== {2'd1, 23'h14AFB0}) begin
                    bad++; $display("FAIL wrap_last port,addr got=%h want=%h",
                                    {oCMD_PORT, oCMD_ADDR}, {2'd1, 23'h14AFB0});
                end
            end
            accept_and_done();
        end
        wait_valid(ok);
        total++;
        if (!ok || oCMD_ADDR !== 23'h100000) begin
            bad++; $display("FAIL wrap_back ok=%b addr got=%h want=100000", ok, oCMD_ADDR);
        end
        iWR1_USEDW = 9'd0;
        accept_and_done();
    endtask

    task automatic test_load();
        bit ok;
        reset_dut();
        iWR0_USEDW = 9'd80;
        wait_valid(ok);
        accept_and_done();
        wait_valid(ok);
        accept_and_done();
        wait_valid(ok);
        total++;
        if (!ok || oCMD_ADDR !== 23'd160) begin
            bad++; $display("FAIL load_pre_addr ok=%b got=%h want=a0", ok, oCMD_ADDR);
        end
`ifdef SDRAM_ARB_STATS_EN
        total++;
        if (oSTAT !== 64'd2) begin
            bad++; $display("FAIL stat_before_load got=%h want=2", oSTAT);
        end
`endif
        iCMD_READY = 1'b1; iLOAD = 1'b1;
        @(negedge iCLK);
        iCMD_READY = 1'b0; iLOAD = 1'b0;
        total++;
        if ({oBUSY, oCMD_ADDR} !== {1'b1, 23'd160}) begin
            bad++; $display("FAIL load_accepted busy,addr got=%h want=%h",
                            {oBUSY, oCMD_ADDR}, {1'b1, 23'd160});
        end
`ifdef SDRAM_ARB_STATS_EN
        total++;
        if (oSTAT !== 64'd0) begin
            bad++; $display("FAIL stat_after_load got=%h want=0", oSTAT);
        end
`endif
        iCMD_DONE = 1'b1;
        @(negedge iCLK);
        iCMD_DONE = 1'b0;
        wait_valid(ok);
        total++;
        if (!ok || {oCMD_PORT, oCMD_ADDR} !== {2'd0, 23'd0}) begin
            bad++; $display("FAIL load_rewound ok=%b port,addr got=%h want=0", ok,
                            {oCMD_PORT, oCMD_ADDR});
        end
        iWR0_USEDW = 9'd0;
        accept_and_done();
`ifdef SDRAM_ARB_STATS_EN
        total++;
        if (oSTAT !== 64'd1) begin
            bad++; $display("FAIL stat_count_after_load got=%h want=1", oSTAT);
        end
`endif
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        reset_dut();
        iWR1_USEDW = 9'd200;
        wait_valid(ok);
        accept_and_done();
        wait_valid(ok);
        iCMD_READY = 1'b1;
        @(negedge iCLK);
        iCMD_READY = 1'b0;
        total++;
        if ({oBUSY, oCMD_ADDR} !== {1'b1, 23'h100050}) begin
            bad++; $display("FAIL busy_before_reset busy,addr got=%h want=%h",
                            {oBUSY, oCMD_ADDR}, {1'b1, 23'h100050});
        end
        #2 iRST_N = 1'b0;
        #1;
        total++;
        if ({oCMD_VALID, oBUSY, cmd_fields()} !== 38'd0) begin
            bad++; $display("FAIL async_reset_outputs got=%h want=0", {oCMD_VALID, oBUSY, cmd_fields()});
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        wait_valid(ok);
        total++;
        if (!ok || {oCMD_PORT, oCMD_ADDR} !== {2'd1, 23'h100000}) begin
            bad++; $display("FAIL after_reset_base ok=%b port,addr got=%h want=%h", ok,
                            {oCMD_PORT, oCMD_ADDR}, {2'd1, 23'h100000});
        end
        iWR1_USEDW = 9'd0;
        accept_and_done();
    endtask

    task automatic test_ignored_handshake();
        bit ok;
        reset_dut();
        repeat (2) @(negedge iCLK);
        iCMD_READY = 1'b1; iCMD_DONE = 1'b1;
        @(negedge iCLK);
        iCMD_READY = 1'b0; iCMD_DONE = 1'b0;
        total++;
        if ({oCMD_VALID, oBUSY} !== 2'b00) begin
            bad++; $display("FAIL idle_ignores valid,busy got=%b want=00", {oCMD_VALID, oBUSY});
        end
        iWR0_USEDW = 9'd80;
        wait_valid(ok);
        iCMD_DONE = 1'b1; iREF_REQ = 1'b1;
        @(negedge iCLK);
        iCMD_DONE = 1'b0;
        total++;
        if (!ok || {oCMD_VALID, oBUSY, oCMD_REFRESH, oCMD_PORT} !== 5'b10000) begin
            bad++; $display("FAIL offer_holds ok=%b valid,busy,ref,port got=%b want=10000", ok,
                            {oCMD_VALID, oBUSY, oCMD_REFRESH, oCMD_PORT});
        end
        iWR0_USEDW = 9'd0;
        iCMD_READY = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        iCMD_READY = 1'b0;
        total++;
        if ({oCMD_VALID, oBUSY} !== 2'b01) begin
            bad++; $display("FAIL busy_ignores_ready valid,busy got=%b want=01", {oCMD_VALID, oBUSY});
        end
        iCMD_DONE = 1'b1;
        @(negedge iCLK);
        iCMD_DONE = 1'b0;
        wait_valid(ok);
        total++;
        if (!ok || cmd_fields() !== {1'b1, 1'b0, 2'd0, 23'd0, 9'd0}) begin
            bad++; $display("FAIL deferred_refresh ok=%b got=%h want=%h", ok, cmd_fields(),
                            {1'b1, 1'b0, 2'd0, 23'd0, 9'd0});
        end
        iREF_REQ = 1'b0;
        accept_and_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_first_write();
        test_priority();
        test_read_rr();
        test_wrap();
        test_load();
        test_reset_mid_busy();
        test_ignored_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
